// File: rtl/pattern_det_param.sv
// pattern_det_param
//   Runtime-programmable serial bit-pattern detector. The pattern, the active
//   length and the overlap mode are loaded with cfg_load_i. Each valid input
//   bit is shifted into a history register. A registered one-cycle match
//   pulse is raised when the newest len bits equal the stored pattern. Every
//   match also advances a saturating counter.
//
//   Optional feature macro: PATDET_MASK_EN
//     When defined, the cfg_mask_i port is added. It is latched with
//     cfg_load_i, and its set bits are don't-care in the compare.
//
// Ports
//   clk            in   1        clock, rising edge
//   reset          in   1        synchronous, active-high
//   cfg_load_i     in   1        latch cfg_* this cycle
//   cfg_pattern_i  in   PAT_LEN  pattern; bit [len-1] is the first-received bit
//   cfg_len_i      in   LEN_W    active length; 0 or >PAT_LEN means PAT_LEN
//   cfg_overlap_i  in   1        1 = overlapping matches, 0 = non-overlapping
//   cfg_mask_i     in   PAT_LEN  (PATDET_MASK_EN only) don't-care bits
//   in_valid_i     in   1        in_bit_i valid this cycle
//   in_bit_i       in   1        serial data bit
//   count_clr_i    in   1        clear match_count_o
//   armed_o        out  1        configured (state RUN)
//   match_o        out  1        one-cycle registered match pulse
//   match_count_o  out  CNT_W    saturating match count
module pattern_det_param #(
  parameter  int PAT_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(PAT_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load_i,
  input  logic [PAT_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
`ifdef PATDET_MASK_EN
  input  logic [PAT_LEN-1:0] cfg_mask_i,
`endif
  input  logic               in_valid_i,
  input  logic               in_bit_i,
  input  logic               count_clr_i,
  output logic               armed_o,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o
);

  typedef enum logic [0:0] {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN);

  state_t             state_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [PAT_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               match_q;
  logic [CNT_W-1:0]   count_q;
`ifdef PATDET_MASK_EN
  logic [PAT_LEN-1:0] mask_q;
`endif

  logic [LEN_W-1:0]   len_d;
  logic [LEN_W-1:0]   fill_d;
  logic [PAT_LEN-1:0] care_s;
  logic [PAT_LEN-1:0] window_s;
  logic               fill_ok_s;
  logic               hit_s;
  logic               match_d;
  logic [CNT_W-1:0]   count_d;

  // Match decode, fill/counter next-state, and normalisation of the loaded length.
  always_comb begin
    len_d = cfg_len_i;
    if ((cfg_len_i == {LEN_W{1'b0}}) || (cfg_len_i > LEN_MAX)) begin
      len_d = LEN_MAX;
    end else begin
      len_d = cfg_len_i;
    end

    // Only the low len_q positions take part in the compare.
    care_s = {PAT_LEN{1'b0}};
    for (int i = 0; i < PAT_LEN; i++) begin
      care_s[i] = (LEN_W'(i) < len_q);
    end
`ifdef PATDET_MASK_EN
    care_s = care_s & ~mask_q;
`endif

    // The incoming bit completes the window in the same cycle.
    window_s  = {hist_q[PAT_LEN-2:0], in_bit_i};
    hit_s     = (((window_s ^ pat_q) & care_s) == {PAT_LEN{1'b0}});
    // fill >= len-1, written as fill+1 >= len so that it cannot underflow.
    fill_ok_s = (({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q});
    match_d   = (state_q == ST_RUN) & ~cfg_load_i & in_valid_i & fill_ok_s & hit_s;

    fill_d = fill_q;
    if (match_d && !ovl_q) begin
      fill_d = {LEN_W{1'b0}};
    end else if (fill_q < len_q) begin
      fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      fill_d = fill_q;
    end

    count_d = count_q;
    if (count_clr_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (match_d && (count_q != CNT_MAX)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Configuration FSM, history shift register, match pulse and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UNCFG;
      pat_q   <= {PAT_LEN{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      ovl_q   <= 1'b0;
      hist_q  <= {PAT_LEN{1'b0}};
      fill_q  <= {LEN_W{1'b0}};
      match_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
`ifdef PATDET_MASK_EN
      mask_q  <= {PAT_LEN{1'b0}};
`endif
    end else begin
      match_q <= match_d;
      count_q <= count_d;
      if (cfg_load_i) begin
        // A load wins over in_valid: the bit in the same cycle is dropped.
        state_q <= ST_RUN;
        pat_q   <= cfg_pattern_i;
        len_q   <= len_d;
        ovl_q   <= cfg_overlap_i;
        hist_q  <= {PAT_LEN{1'b0}};
        fill_q  <= {LEN_W{1'b0}};
`ifdef PATDET_MASK_EN
        mask_q  <= cfg_mask_i;
`endif
      end else begin
        case (state_q)
          ST_UNCFG: begin
            state_q <= ST_UNCFG;
          end
          ST_RUN: begin
            if (in_valid_i) begin
              hist_q <= window_s;
              fill_q <= fill_d;
            end
          end
          default: begin
            state_q <= ST_UNCFG;
          end
        endcase
      end
    end
  end

  assign armed_o       = (state_q == ST_RUN);
  assign match_o       = match_q;
  assign match_count_o = count_q;

endmodule

// File: tb/tb_pattern_det_param.sv
module tb_pattern_det_param;

  localparam int PAT_LEN = 8;
  localparam int LEN_W   = $clog2(PAT_LEN + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_load = 1'b0;
  logic [PAT_LEN-1:0] cfg_pattern = 8'h00;
  logic [LEN_W-1:0]   cfg_len = 4'd0;
  logic               cfg_overlap = 1'b0;
`ifdef PATDET_MASK_EN
  logic [PAT_LEN-1:0] cfg_mask = 8'h00;
`endif
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               count_clr = 1'b0;

  logic               armed, match;
  logic [15:0]        match_count;
  logic               armed2, match2;
  logic [1:0]         match_count2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pattern_det_param #(.PAT_LEN(PAT_LEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap),
`ifdef PATDET_MASK_EN
    .cfg_mask_i(cfg_mask),
`endif
    .in_valid_i(in_valid), .in_bit_i(in_bit), .count_clr_i(count_clr),
    .armed_o(armed), .match_o(match), .match_count_o(match_count)
  );

  pattern_det_param #(.PAT_LEN(PAT_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap),
`ifdef PATDET_MASK_EN
    .cfg_mask_i(cfg_mask),
`endif
    .in_valid_i(in_valid), .in_bit_i(in_bit), .count_clr_i(count_clr),
    .armed_o(armed2), .match_o(match2), .match_count_o(match_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  // Send one valid bit and check the match pulse one cycle later.
  task automatic send(input logic b, input logic exp_match, input string tag);
    in_valid = 1'b1; in_bit = b;
    tick();
    in_valid = 1'b0;
    chk(tag, {31'd0, match}, {31'd0, exp_match});
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_match", {31'd0, match}, 32'd0);
    end
  endtask

  task automatic clr();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_count", {16'd0, match_count}, 32'd0);

    // Unconfigured: valid bits are ignored.
    send(1'b1, 1'b0, "uncfg_bit");
    chk("uncfg_armed", {31'd0, armed}, 32'd0);

    // 1: overlap
    load(8'b0000_1011, 4'd4, 1'b1);
    chk("t1_armed", {31'd0, armed}, 32'd1);
    send(1'b1, 1'b0, "t1_b1"); send(1'b0, 1'b0, "t1_b2"); send(1'b1, 1'b0, "t1_b3");
    send(1'b1, 1'b1, "t1_b4"); send(1'b0, 1'b0, "t1_b5"); send(1'b1, 1'b0, "t1_b6");
    send(1'b1, 1'b1, "t1_b7");
    tick();
    chk("t1_pulse_end", {31'd0, match}, 32'd0);
    chk("t1_count", {16'd0, match_count}, 32'd2);

    // 2: non-overlap
    clr();
    load(8'b0000_1011, 4'd4, 1'b0);
    send(1'b1, 1'b0, "t2_b1"); send(1'b0, 1'b0, "t2_b2"); send(1'b1, 1'b0, "t2_b3");
    send(1'b1, 1'b1, "t2_b4"); send(1'b0, 1'b0, "t2_b5"); send(1'b1, 1'b0, "t2_b6");
    send(1'b1, 1'b0, "t2_b7"); send(1'b1, 1'b0, "t2_b8");
    chk("t2_count", {16'd0, match_count}, 32'd1);

    // 3: gaps are transparent
    clr();
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0, "t3_b1"); gap(1);
    send(1'b0, 1'b0, "t3_b2"); send(1'b1, 1'b0, "t3_b3"); gap(3);
    send(1'b1, 1'b1, "t3_b4");
    tick();
    chk("t3_pulse_end", {31'd0, match}, 32'd0);
    chk("t3_count", {16'd0, match_count}, 32'd1);

    // 4: reset mid-stream
    send(1'b1, 1'b0, "t4_b1"); send(1'b0, 1'b0, "t4_b2"); send(1'b1, 1'b0, "t4_b3");
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t4_armed", {31'd0, armed}, 32'd0);
    chk("t4_count", {16'd0, match_count}, 32'd0);
    send(1'b1, 1'b0, "t4_after_rst");
    chk("t4_count2", {16'd0, match_count}, 32'd0);
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0, "t4_r1"); send(1'b0, 1'b0, "t4_r2"); send(1'b1, 1'b0, "t4_r3");
    send(1'b1, 1'b1, "t4_r4");

    // 5: saturation (CNT_W=2 instance), clr vs match, load vs valid
    clr();
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0, "t5_a1"); send(1'b0, 1'b0, "t5_a2"); send(1'b1, 1'b0, "t5_a3");
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b1, "t5_m");
      if (k < 4) begin
        send(1'b0, 1'b0, "t5_z"); send(1'b1, 1'b0, "t5_o");
      end
    end
    chk("t5_sat", {30'd0, match_count2}, 32'd3);
    chk("t5_cnt16", {16'd0, match_count}, 32'd5);
    send(1'b0, 1'b0, "t5_c1"); send(1'b1, 1'b0, "t5_c2");
    count_clr = 1'b1;
    send(1'b1, 1'b1, "t5_clr_match");
    count_clr = 1'b0;
    chk("t5_clr_cnt", {16'd0, match_count}, 32'd0);
    chk("t5_clr_sat", {30'd0, match_count2}, 32'd0);
    // The bit presented with the load must be discarded.
    cfg_load = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    chk("t5_load_match", {31'd0, match}, 32'd0);
    send(1'b0, 1'b0, "t5_d1"); send(1'b1, 1'b0, "t5_d2"); send(1'b1, 1'b0, "t5_discard");
    chk("t5_cnt_end", {16'd0, match_count}, 32'd0);

    // len=0 means full PAT_LEN
    load(8'hA5, 4'd0, 1'b0);
    send(1'b1, 1'b0, "l0_1"); send(1'b0, 1'b0, "l0_2"); send(1'b1, 1'b0, "l0_3");
    send(1'b0, 1'b0, "l0_4"); send(1'b0, 1'b0, "l0_5"); send(1'b1, 1'b0, "l0_6");
    send(1'b0, 1'b0, "l0_7"); send(1'b1, 1'b1, "l0_8");

    // 6: mask
`ifdef PATDET_MASK_EN
    cfg_mask = 8'b0000_0100;
`endif
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0, "t6_1"); send(1'b1, 1'b0, "t6_2"); send(1'b1, 1'b0, "t6_3");
`ifdef PATDET_MASK_EN
    send(1'b1, 1'b1, "t6_mask_hit");
`else
    send(1'b1, 1'b0, "t6_exact_miss");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
